// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, icache fetch and IF/ID register with stall and redirect handling
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] icache_address,
  input  logic [DATA_WIDTH-1:0] icache_instruction,
  input  logic                  icache_busywait,
  input  logic                  id_stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] id_instruction,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc_plus4,
  output logic                  id_valid
);

  typedef enum logic {ISSUE, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    pending_redirect_q, pending_redirect_d;
  logic [ADDR_WIDTH-1:0]   pending_target_q, pending_target_d;
  logic [DATA_WIDTH-1:0]   id_instruction_q, id_instruction_d;
  logic [ADDR_WIDTH-1:0]   id_pc_q, id_pc_d;
  logic [ADDR_WIDTH-1:0]   id_pc_plus4_q, id_pc_plus4_d;
  logic                    id_valid_q, id_valid_d;

  logic [ADDR_WIDTH-1:0]   target_aligned;
  logic [ADDR_WIDTH-1:0]   pc_plus4;

  assign target_aligned = branch_target & ~ADDR_WIDTH'(3);
  assign pc_plus4       = pc_q + ADDR_WIDTH'(4);

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    pending_redirect_d = pending_redirect_q;
    pending_target_d   = pending_target_q;
    id_instruction_d   = id_instruction_q;
    id_pc_d            = id_pc_q;
    id_pc_plus4_d      = id_pc_plus4_q;
    id_valid_d         = id_valid_q;

    if (branch_taken) begin
      id_valid_d = 1'b0;
      // During a refill the icache still uses the live address, so the redirect is parked.
      if (state_q == ISSUE || !icache_busywait) begin
        pc_d               = target_aligned;
        state_d            = ISSUE;
        pending_redirect_d = 1'b0;
      end else begin
        pending_redirect_d = 1'b1;
        pending_target_d   = target_aligned;
      end
    end else if (state_q == ISSUE) begin
      state_d = WAIT;
      if (!id_stall) id_valid_d = 1'b0;
    end else if (icache_busywait) begin
      if (!id_stall) id_valid_d = 1'b0;
    end else if (pending_redirect_q) begin
      pc_d               = pending_target_q;
      pending_redirect_d = 1'b0;
      state_d            = ISSUE;
      if (!id_stall) id_valid_d = 1'b0;
    end else if (!id_stall) begin
      id_instruction_d = icache_instruction;
      id_pc_d          = pc_q;
      id_pc_plus4_d    = pc_plus4;
      id_valid_d       = 1'b1;
      pc_d             = pc_plus4;
      state_d          = ISSUE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q            <= ISSUE;
      pc_q               <= RESET_PC;
      pending_redirect_q <= 1'b0;
      pending_target_q   <= '0;
      id_instruction_q   <= '0;
      id_pc_q            <= '0;
      id_pc_plus4_q      <= '0;
      id_valid_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      pending_redirect_q <= pending_redirect_d;
      pending_target_q   <= pending_target_d;
      id_instruction_q   <= id_instruction_d;
      id_pc_q            <= id_pc_d;
      id_pc_plus4_q      <= id_pc_plus4_d;
      id_valid_q         <= id_valid_d;
    end
  end

  assign icache_address = pc_q;
  assign id_instruction = id_instruction_q;
  assign id_pc          = id_pc_q;
  assign id_pc_plus4    = id_pc_plus4_q;
  assign id_valid       = id_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  icache_address;
  logic [31:0] icache_instruction;
  logic        icache_busywait;
  logic        id_stall;
  logic        branch_taken;
  logic [9:0]  branch_target;
  logic [31:0] id_instruction;
  logic [9:0]  id_pc;
  logic [9:0]  id_pc_plus4;
  logic        id_valid;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock              (clock),
    .reset              (reset),
    .icache_address     (icache_address),
    .icache_instruction (icache_instruction),
    .icache_busywait    (icache_busywait),
    .id_stall           (id_stall),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .id_instruction     (id_instruction),
    .id_pc              (id_pc),
    .id_pc_plus4        (id_pc_plus4),
    .id_valid           (id_valid)
  );

  function automatic logic [31:0] word(input logic [9:0] a);
    return {16'hC0DE, 6'h00, a};
  endfunction

  assign icache_instruction = word(icache_address);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_capture(input string tag, input logic [9:0] pc);
    check_eq({tag, "_valid"}, {31'h0, id_valid}, 32'h1);
    check_eq({tag, "_pc"}, {22'h0, id_pc}, {22'h0, pc});
    check_eq({tag, "_pc4"}, {22'h0, id_pc_plus4}, {22'h0, pc + 10'd4});
    check_eq({tag, "_instr"}, id_instruction, word(pc));
  endtask

  initial begin
    reset = 1'b0; icache_busywait = 1'b0; id_stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    tick(2);
    check_eq("rst_addr", {22'h0, icache_address}, 32'h0);
    check_eq("rst_valid", {31'h0, id_valid}, 32'h0);
    check_eq("rst_instr", id_instruction, 32'h0);

    // Back-to-back hits: one capture every two cycles
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check_eq("hit_addr", {22'h0, icache_address}, k * 4);
      check_eq("hit_bubble", {31'h0, id_valid}, 32'h0);
      tick(1);
      expect_capture("hit", 10'(k * 4));
    end

    // Miss at 0x010
    tick(1);
    icache_busywait = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check_eq("miss_addr", {22'h0, icache_address}, 32'h010);
      check_eq("miss_valid", {31'h0, id_valid}, 32'h0);
    end
    icache_busywait = 1'b0;
    tick(1);
    expect_capture("miss", 10'h010);

    tick(2); expect_capture("f14", 10'h014);
    tick(2); expect_capture("f18", 10'h018);
    tick(2); expect_capture("f1c", 10'h01C);

    // Decode stall while 0x020 is available
    id_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check_eq("stall_addr", {22'h0, icache_address}, 32'h020);
      expect_capture("stall_hold", 10'h01C);
    end
    id_stall = 1'b0;
    tick(1);
    expect_capture("stall_rel", 10'h020);

    // Redirect on hit
    tick(1);
    check_eq("pre_br_addr", {22'h0, icache_address}, 32'h024);
    branch_taken = 1'b1; branch_target = 10'h1A7;
    tick(1);
    branch_taken = 1'b0;
    check_eq("br_addr", {22'h0, icache_address}, 32'h1A4);
    check_eq("br_valid", {31'h0, id_valid}, 32'h0);
    check_eq("br_nocap", {22'h0, id_pc}, 32'h020);
    tick(2);
    expect_capture("br_cap", 10'h1A4);

    // Redirects while a miss is in service
    tick(1);
    icache_busywait = 1'b1;
    tick(1);
    branch_taken = 1'b1; branch_target = 10'h040;
    tick(1);
    branch_taken = 1'b0;
    check_eq("pend_addr1", {22'h0, icache_address}, 32'h1A8);
    tick(1);
    check_eq("pend_addr2", {22'h0, icache_address}, 32'h1A8);
    branch_taken = 1'b1; branch_target = 10'h080;
    tick(1);
    branch_taken = 1'b0;
    check_eq("pend_addr3", {22'h0, icache_address}, 32'h1A8);
    icache_busywait = 1'b0;
    tick(1);
    check_eq("pend_resolve", {22'h0, icache_address}, 32'h080);
    check_eq("pend_valid", {31'h0, id_valid}, 32'h0);
    check_eq("pend_nocap", {22'h0, id_pc}, 32'h1A4);
    tick(2);
    expect_capture("pend_cap", 10'h080);

    // Redirect from ISSUE to the top word, then wrap
    branch_taken = 1'b1; branch_target = 10'h3FE;
    tick(1);
    branch_taken = 1'b0;
    check_eq("wrap_addr", {22'h0, icache_address}, 32'h3FC);
    tick(2);
    check_eq("wrap_pc", {22'h0, id_pc}, 32'h3FC);
    check_eq("wrap_pc4", {22'h0, id_pc_plus4}, 32'h000);
    check_eq("wrap_next", {22'h0, icache_address}, 32'h000);
    tick(2); expect_capture("w0", 10'h000);
    tick(2); expect_capture("w4", 10'h004);

    // Reset in the middle of a miss
    id_stall = 1'b1;
    tick(1);
    id_stall = 1'b0;
    icache_busywait = 1'b1;
    tick(1);
    check_eq("mr_pre_addr", {22'h0, icache_address}, 32'h008);
    check_eq("mr_pre_valid", {31'h0, id_valid}, 32'h0);
    id_stall = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check_eq("mr_addr", {22'h0, icache_address}, 32'h000);
    check_eq("mr_valid", {31'h0, id_valid}, 32'h0);
    check_eq("mr_pc", {22'h0, id_pc}, 32'h0);
    reset = 1'b1; icache_busywait = 1'b0; id_stall = 1'b0;
    tick(2);
    expect_capture("mr_cap", 10'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
